pc_sequencer: RTL

//  Consumer end of the PC-source select path: registers the program counter and applies the
//  2-bit pc_src code from the branch/jump select logic.

---
 rtl/pc_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer: program counter register with PC-source select, N/Z flags and
// a jump-through-memory pointer fetch (req/ack with timeout).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_sequencer #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [1:0]      pc_src,
    input  logic [PC_W-1:0] target,
    input  logic            alu_n,
    input  logic            alu_z,
    input  logic            flag_we,
    output logic            n,
    output logic            z,
    output logic [PC_W-1:0] pc,
    output logic            pc_upd,
    output logic            busy,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic [PC_W-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            err
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_JM_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              n_q, n_d, z_q, z_d;
    logic              pc_upd_q, pc_upd_d;
    logic              busy_q, busy_d;
    logic              mem_req_q, mem_req_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            mem_addr_q <= '0;
            cnt_q      <= '0;
            n_q        <= 1'b0;
            z_q        <= 1'b0;
            pc_upd_q   <= 1'b0;
            busy_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            z_q        <= z_d;
            pc_upd_q   <= pc_upd_d;
            busy_q     <= busy_d;
            mem_req_q  <= mem_req_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        z_d        = z_q;
        pc_upd_d   = 1'b0;
        busy_d     = busy_q;
        mem_req_d  = mem_req_q;
        err_d      = 1'b0;

        // Flags load independently of en and of the sequencing state.
        if (flag_we) begin
            n_d = alu_n;
            z_d = alu_z;
        end

        case (state_q)
            ST_RUN: begin
                if (en) begin
                    case (pc_src)
                        2'd1: begin
                            pc_d     = target;
                            pc_upd_d = 1'b1;
                        end
                        2'd2: begin
                            mem_req_d  = 1'b1;
                            mem_addr_d = target;
                            cnt_d      = '0;
                            busy_d     = 1'b1;
                            state_d    = ST_JM_WAIT;
                        end
                        2'd3: begin
                            pc_d     = pc_q + PC_ONE;
                            pc_upd_d = 1'b1;
                            err_d    = 1'b1;
                        end
                        default: begin
                            pc_d     = pc_q + PC_ONE;
                            pc_upd_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_JM_WAIT: begin
                // An ack arriving on the final allowed cycle still wins over the abort.
                if (mem_ack) begin
                    pc_d      = mem_rdata;
                    pc_upd_d  = 1'b1;
                    mem_req_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = ST_RUN;
                end else if (cnt_q == CNT_LAST) begin
                    pc_d      = pc_q + PC_ONE;
                    pc_upd_d  = 1'b1;
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign n        = n_q;
    assign z        = z_q;
    assign pc       = pc_q;
    assign pc_upd   = pc_upd_q;
    assign busy     = busy_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign err      = err_q;

endmodule

`default_nettype wire
